register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x 32-bit integer register file for the RV32I datapath, sitting between decode and execute.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd), clocked on the rising edge.
- Register x0 is hardwired to zero.
- Synchronous active-high reset clears all registers.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clears all registers at the rising edge of clk.
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- rd  input  5  write address.
- write_data  input  32  data to write to register rd.
- RegWrite  input  1  write enable, active high.
- read_data1  output  32  contents of register rs1 (combinational).
- read_data2  output  32  contents of register rs2 (combinational).

Behaviour:
- Storage: NREGS registers of XLEN bits. Only x0 is special.
- Reset:
  - One clock, no asynchronous paths.
  - If reset=1 at a rising clk edge, every register becomes 0, and read_data1/read_data2 read 0 afterwards.
  - Reset has priority over any write presented in the same cycle.
  - Reset asserted mid-operation discards all prior contents.
  - Before the first reset edge, register contents are undefined.
- Write:
  - At a rising clk edge with reset=0, RegWrite=1 and rd!=0: reg[rd] <= write_data.
  - Latency is 1 edge; the new value is visible on the read ports immediately after that edge.
  - RegWrite=0: no register changes, regardless of rd or write_data.
  - rd=0 with RegWrite=1: the write is ignored and x0 stays 0.
- Read:
  - Purely combinational: read_data1 = reg[rs1], read_data2 = reg[rs2].
  - Outputs update in the same cycle that rs1, rs2 or the register contents change.
  - rs1 or rs2 equal to 0 always returns 0.
  - Both ports may address the same register; both return the same value.
- Read-during-write to the same address:
  - No internal bypass.
  - Before the edge, the read port shows the old value.
  - After the edge, it shows write_data.
  - Forwarding is the pipeline's responsibility.
- Any rs1/rs2/rd value in 0..31 is legal; there is no out-of-range case at NREGS=32.
- Inputs must be stable around the rising edge. There are no handshakes, no stalls and no internal state machine.

Test Plan:
1. Reset then read: reset=1 for one rising edge, then rs1=5, rs2=2 -> read_data1=0x00000000, read_data2=0x00000000.
2. Back-to-back writes, then read:
   - After reset, write rd=5 with write_data=0xA47DEFFF and RegWrite=1 for one edge.
   - Next edge, write rd=2 with write_data=0x3EDCBA00.
   - Drop RegWrite, then set rs1=2, rs2=5 -> read_data1=0x3EDCBA00, read_data2=0xA47DEFFF.
3. x0 protection: RegWrite=1, rd=0, write_data=0xFFFFFFFF for one edge; rs1=0 -> read_data1=0x00000000.
4. Write disable: with reg5=0xA47DEFFF, set RegWrite=0, rd=5, write_data=0x12345678 for several edges -> read of rs1=5 still returns 0xA47DEFFF.
5. Read-during-write: reg7=0x11111111; set rs1=7 and present rd=7, write_data=0x22222222, RegWrite=1.
   - Before the edge, read_data1=0x11111111.
   - After the edge, read_data1=0x22222222.
6. Reset vs write collision: reset=1 and RegWrite=1, rd=3, write_data=0xDEADBEEF at the same edge -> reg3 reads 0x00000000, and previously written regs 2 and 5 also read 0.

Source files
------------

// File: rtl/register_file.sv
// register_file: RV32I integer register file, XLEN x NREGS.
// Two combinational read ports and one write port that updates on the clock edge.
// x0 is hardwired to zero. Synchronous active-high reset clears every entry.
module register_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   write_data,
    input  logic              RegWrite,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [NREGS-1:0]           wr_sel;

    // Per-entry write select. Entry 0 never gets a select, so x0 cannot be written.
    for (genvar i = 0; i < NREGS; i++) begin : g_sel
        if (i == 0) begin : g_x0
            assign wr_sel[i] = 1'b0;
        end else begin : g_xn
            assign wr_sel[i] = RegWrite && (rd == ADDR_W'(i));
        end
    end

    // Next-state: hold every entry except the one selected by rd.
    // Entry 0 is also forced to zero here, so it stays zero even before the first reset.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_sel[i]) begin
                regs_d[i] = write_data;
            end
        end
        regs_d[0] = '0;
    end

    // State update. Reset is checked first, so it wins over a write presented at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational reads. There is no write bypass: a read of rd shows the old value
    // until the edge. The explicit zero on address 0 also covers the interval before
    // the first reset, when the contents of entry 0 are still unknown.
    always_comb begin
        read_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
        read_data2 = (rs2 == '0) ? '0 : regs_q[rs2];
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] write_data;
    logic        RegWrite;
    logic [31:0] read_data1, read_data2;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: a plain array of register values, plus a flag recording
    // whether the contents are known (they become known at the first reset).
    logic [31:0] mdl [32];
    bit          mdl_valid = 1'b0;
    bit          cmp_en    = 1'b0;

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .write_data (write_data),
        .RegWrite   (RegWrite),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mdl[a];
    endfunction

    // Update the reference at each rising edge from the inputs presented at that edge.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mdl_valid = 1'b1;
        end else if (RegWrite === 1'b1 && rd != 5'd0) begin
            mdl[rd] = write_data;
        end
    end

    // Compare both read ports against the reference in the middle of every cycle.
    always @(negedge clk) begin
        if (cmp_en && mdl_valid) begin
            chk("cmp_rd1", read_data1, mdl_read(rs1));
            chk("cmp_rd2", read_data2, mdl_read(rs2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; rs1 = '0; rs2 = '0; rd = '0; write_data = '0;
        #1;
        // Address 0 reads zero even before any reset.
        chk("x0_prereset", read_data1, 32'h0);

        // 1. Reset then read
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cmp_en = 1'b1;
        rs1 = 5'd5; rs2 = 5'd2;
        #1;
        chk("rst_rd1", read_data1, 32'h0);
        chk("rst_rd2", read_data2, 32'h0);

        // 2. Back-to-back writes
        RegWrite = 1'b1; rd = 5'd5; write_data = 32'hA47DEFFF;
        cyc();
        rd = 5'd2; write_data = 32'h3EDCBA00;
        cyc();
        RegWrite = 1'b0; rs1 = 5'd2; rs2 = 5'd5;
        #1;
        chk("b2b_rd1", read_data1, 32'h3EDCBA00);
        chk("b2b_rd2", read_data2, 32'hA47DEFFF);
        chk("mdl_r5", mdl[5], 32'hA47DEFFF);

        // 3. x0 protection
        RegWrite = 1'b1; rd = 5'd0; write_data = 32'hFFFFFFFF;
        cyc();
        RegWrite = 1'b0; rs1 = 5'd0;
        #1;
        chk("x0_rd1", read_data1, 32'h0);

        // 4. Write disable
        RegWrite = 1'b0; rd = 5'd5; write_data = 32'h12345678;
        repeat (3) cyc();
        rs1 = 5'd5;
        #1;
        chk("wdis_rd1", read_data1, 32'hA47DEFFF);

        // 5. Read-during-write
        RegWrite = 1'b1; rd = 5'd7; write_data = 32'h11111111;
        cyc();
        rs1 = 5'd7; rd = 5'd7; write_data = 32'h22222222; RegWrite = 1'b1;
        #1;
        chk("rdw_before", read_data1, 32'h11111111);
        cyc();
        chk("rdw_after", read_data1, 32'h22222222);
        RegWrite = 1'b0;

        // 6. Reset vs write collision
        reset = 1'b1; RegWrite = 1'b1; rd = 5'd3; write_data = 32'hDEADBEEF;
        cyc();
        reset = 1'b0; RegWrite = 1'b0; rs1 = 5'd3; rs2 = 5'd2;
        #1;
        chk("coll_r3", read_data1, 32'h0);
        chk("coll_r2", read_data2, 32'h0);
        rs1 = 5'd5;
        #1;
        chk("coll_r5", read_data1, 32'h0);

        // Randomized traffic: bursts of writes, occasional resets, reads biased toward rd.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            RegWrite   = $urandom_range(0, 2) != 0;
            rd         = 5'($urandom_range(0, 31));
            write_data = $urandom;
            rs1        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2        = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 31));
            cyc();
        end

        reset = 1'b0; RegWrite = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
